// File: rtl/uart_mem_pkg.sv
// Shared types and helpers for the UART memory dumper.
// Holds the dump FSM state encoding and word/byte sizing helpers.
package uart_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SEND,
        WAIT_TX,
        FINISH
    } dump_state_t;

    localparam int DEFAULT_INSTR_WIDTH = 32;
    localparam int BYTES_PER_WORD      = DEFAULT_INSTR_WIDTH / 8;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/uart_mem_dumper_uart.sv
// UART_wrapper: 8N1-capable serial transmitter and receiver.
// Transmit is fully framed; the receiver samples mid-bit after a 2-FF sync.
module UART_wrapper #(
    parameter int CLK_PER_BIT = 50,
    parameter int dataWidth   = 8,
    parameter int parityBits  = 0,
    parameter int stopBits    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic [dataWidth-1:0] tx_byte,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx,
    input  logic                 rx,
    output logic [dataWidth-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_err
);

    localparam int CW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int FW    = dataWidth + parityBits + stopBits;
    localparam int TBW   = $clog2(FW + 1);
    localparam int DBITS = dataWidth + parityBits;
    localparam int RBW   = (DBITS > 1) ? $clog2(DBITS) : 1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    logic [FW-1:0]    frame;
    logic [FW-1:0]    tx_shreg;
    logic [CW-1:0]    tx_cnt;
    logic [TBW-1:0]   tx_bit;
    logic             tx_bit_end;

    rx_state_t        rx_state;
    rx_state_t        rx_state_next;
    logic             rx_meta;
    logic             rx_sync;
    logic [CW-1:0]    rx_cnt;
    logic [RBW-1:0]   rx_bit;
    logic [DBITS-1:0] rx_shreg;
    logic             rx_half;
    logic             rx_bit_end;

    // Build the post-start-bit frame: data LSB first, optional even parity, stop bits
    always_comb begin
        frame                  = '1;
        frame[dataWidth-1:0]   = tx_byte;
        if (parityBits != 0) begin
            frame[dataWidth] = ^tx_byte;
        end
    end

    assign tx_bit_end = (tx_cnt == CW'(CLK_PER_BIT - 1));

    // Transmitter: start bit on accept, then shift frame out one bit period each
    always_ff @(posedge clk) begin
        if (rst) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_shreg <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_busy) begin
                if (tx_en) begin
                    tx       <= 1'b0;
                    tx_busy  <= 1'b1;
                    tx_shreg <= frame;
                    tx_cnt   <= '0;
                    tx_bit   <= '0;
                end
            end else if (tx_bit_end) begin
                tx_cnt <= '0;
                if (tx_bit == TBW'(FW)) begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    tx       <= tx_shreg[0];
                    tx_shreg <= tx_shreg >> 1;
                    tx_bit   <= tx_bit + TBW'(1);
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

    assign rx_half    = (rx_cnt == CW'(CLK_PER_BIT / 2 - 1));
    assign rx_bit_end = (rx_cnt == CW'(CLK_PER_BIT - 1));

    // Receiver state register
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_state_next;
        end
    end

    // Receiver next-state: confirm start at mid-bit, then walk data and stop
    always_comb begin
        rx_state_next = rx_state;
        unique case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) rx_state_next = RX_START;
            end
            RX_START: begin
                if (rx_half) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_bit_end && rx_bit == RBW'(DBITS - 1)) begin
                    rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // Receiver datapath: synchronizer, bit timer, shift register, result pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
                RX_START: begin
                    rx_cnt <= rx_half ? '0 : rx_cnt + CW'(1);
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_sync, rx_shreg[DBITS-1:1]};
                        rx_bit   <= rx_bit + RBW'(1);
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_data  <= rx_shreg[dataWidth-1:0];
                        rx_valid <= 1'b1;
                        rx_err   <= !rx_sync || ((parityBits != 0) && (^rx_shreg));
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/uart_mem_dumper.sv
// uart_mem_dumper: streams a range of words from an external synchronous
// memory out over a UART, MSB byte first, with busy/done status.
module uart_mem_dumper
    import uart_mem_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 256,
    parameter int CLK_PER_BIT = 50
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(DEPTH)-1:0] start_addr,
    input  logic [$clog2(DEPTH):0]   word_count,
    output logic [$clog2(DEPTH)-1:0] rd_addr,
    input  logic [INSTR_WIDTH-1:0]   rd_data,
    output logic                     uart_tx,
    output logic                     busy,
    output logic                     done
);

    localparam int AW  = $clog2(DEPTH);
    localparam int BPW = bytes_per_word(INSTR_WIDTH);
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

    dump_state_t            state;
    dump_state_t            state_next;
    logic [AW-1:0]          cur_addr;
    logic [AW:0]            remaining;
    logic [BIW-1:0]         byte_idx;
    logic [INSTR_WIDTH-1:0] shift_reg;
    logic                   tx_en;
    logic                   tx_busy;
    logic                   tx_done;
    logic [7:0]             tx_byte;
    logic                   last_byte;
    logic                   last_word;
    logic [7:0]             rx_data_unused;
    logic                   rx_valid_unused;
    logic                   rx_err_unused;

    assign rd_addr   = cur_addr;
    assign tx_byte   = shift_reg[INSTR_WIDTH-1 -: 8];
    assign last_byte = (byte_idx == BIW'(BPW - 1));
    assign last_word = (remaining <= (AW + 1)'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one read per word, one UART frame per byte
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (word_count == '0) ? FINISH : FETCH;
                end
            end
            FETCH:   state_next = CAPTURE;
            CAPTURE: state_next = SEND;
            SEND: begin
                if (!tx_busy) state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    if (!last_byte)     state_next = SEND;
                    else if (last_word) state_next = FINISH;
                    else                state_next = FETCH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        tx_en = (state == SEND) && !tx_busy;
        busy  = (state == FETCH) || (state == CAPTURE) ||
                (state == SEND)  || (state == WAIT_TX);
        done  = (state == FINISH);
    end

    // Datapath: address/count bookkeeping and byte shifting
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && word_count != '0) begin
                        cur_addr  <= start_addr;
                        remaining <= word_count;
                    end
                end
                CAPTURE: begin
                    shift_reg <= rd_data;
                    byte_idx  <= '0;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        if (!last_byte) begin
                            shift_reg <= shift_reg << 8;
                            byte_idx  <= byte_idx + BIW'(1);
                        end else begin
                            if (remaining != '0) begin
                                remaining <= remaining - (AW + 1)'(1);
                            end
                            cur_addr <= (cur_addr == AW'(DEPTH - 1)) ?
                                        '0 : cur_addr + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    UART_wrapper #(
        .CLK_PER_BIT(CLK_PER_BIT),
        .dataWidth  (8),
        .parityBits (0),
        .stopBits   (1)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .tx_en   (tx_en),
        .tx_byte (tx_byte),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .tx      (uart_tx),
        .rx      (1'b1),
        .rx_data (rx_data_unused),
        .rx_valid(rx_valid_unused),
        .rx_err  (rx_err_unused)
    );

endmodule

// File: tb/tb_uart_mem_dumper.sv
// Scoreboard bench for uart_mem_dumper: expected bytes are queued at
// stimulus time and a serial monitor decodes uart_tx and compares.
module tb_uart_mem_dumper;

    localparam int DEPTH = 256;
    localparam int CPB   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  start_addr;
    logic [8:0]  word_count;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        uart_tx;
    logic        busy;
    logic        done;

    logic [31:0] mem [DEPTH];
    logic [7:0]  exp_q [$];

    int checks    = 0;
    int errors    = 0;
    int bytes_rx  = 0;
    int done_cnt  = 0;
    bit rst_seen  = 0;

    uart_mem_dumper #(
        .INSTR_WIDTH(32),
        .DEPTH      (DEPTH),
        .CLK_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .word_count(word_count),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_word(input int addr);
        logic [31:0] w;
        w = mem[addr];
        for (int k = 3; k >= 0; k--) exp_q.push_back(w[k*8 +: 8]);
    endtask

    task automatic pulse_start(input int addr, input int cnt);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 8'(addr);
        word_count = 9'(cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit seen,
                             output int busy_bad);
        seen     = 0;
        busy_bad = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (!busy) busy_bad++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) rst_seen = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    // Serial monitor: decode one 8N1 frame, pop and compare
    initial begin
        logic [7:0] b;
        bit         frame_ok;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                rst_seen = 0;
                repeat (CPB / 2) @(negedge clk);
                frame_ok = (uart_tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                frame_ok = frame_ok && (uart_tx === 1'b1);
                if (!rst_seen) begin
                    bytes_rx++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (b !== e || !frame_ok) begin
                            errors++;
                            $display("FAIL uart_byte: got %0h framing %0d expected %0h",
                                     b, frame_ok, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit seen;
        int bb;
        int d0;
        int b0;
        int tx_low;
        int busy_hi;

        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        mem[0]   = 32'h12345678;
        mem[5]   = 32'hA0A1A2A3;
        mem[6]   = 32'hB0B1B2B3;
        mem[7]   = 32'hC0C1C2C3;
        mem[255] = 32'hDEADBEEF;

        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        word_count = '0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_uart_tx", 64'(uart_tx), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_rd_addr", 64'(rd_addr), 64'd0);

        // single word, big-endian bytes
        push_word(0);
        d0 = done_cnt;
        pulse_start(0, 1);
        wait_done(2000, seen, bb);
        check("t1_done_seen", 64'(seen), 64'd1);
        check("t1_busy_gaps", 64'(bb), 64'd0);
        repeat (4) @(negedge clk);
        check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // three words in address order
        push_word(5);
        push_word(6);
        push_word(7);
        pulse_start(5, 3);
        wait_done(6000, seen, bb);
        check("t2_done_seen", 64'(seen), 64'd1);
        check("t2_busy_gaps", 64'(bb), 64'd0);
        repeat (4) @(negedge clk);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // address wrap 255 -> 0
        push_word(255);
        push_word(0);
        pulse_start(255, 2);
        check("t3_first_addr", 64'(rd_addr), 64'd255);
        wait_done(4000, seen, bb);
        check("t3_done_seen", 64'(seen), 64'd1);
        check("t3_final_addr", 64'(rd_addr), 64'd1);
        repeat (4) @(negedge clk);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // zero-length dump
        d0      = done_cnt;
        b0      = bytes_rx;
        tx_low  = 0;
        busy_hi = 0;
        pulse_start(0, 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_hi++;
        end
        check("t4_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t4_tx_low", 64'(tx_low), 64'd0);
        check("t4_busy_high", 64'(busy_hi), 64'd0);
        check("t4_no_bytes", 64'(bytes_rx - b0), 64'd0);

        // second start during a dump is ignored
        d0 = done_cnt;
        b0 = bytes_rx;
        push_word(0);
        pulse_start(0, 1);
        repeat (50) @(posedge clk);
        pulse_start(5, 3);
        wait_done(2000, seen, bb);
        check("t5_done_seen", 64'(seen), 64'd1);
        repeat (200) @(negedge clk);
        check("t5_byte_count", 64'(bytes_rx - b0), 64'd4);
        check("t5_done_pulses", 64'(done_cnt - d0), 64'd1);

        // reset mid-frame, then a clean dump
        push_word(5);
        push_word(6);
        push_word(7);
        d0 = done_cnt;
        pulse_start(5, 3);
        repeat (60) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_tx_after_rst", 64'(uart_tx), 64'd1);
        check("t6_busy_after_rst", 64'(busy), 64'd0);
        check("t6_addr_after_rst", 64'(rd_addr), 64'd0);
        exp_q.delete();
        repeat (100) @(negedge clk);
        check("t6_no_done_abort", 64'(done_cnt - d0), 64'd0);
        b0 = bytes_rx;
        push_word(0);
        pulse_start(0, 1);
        wait_done(2000, seen, bb);
        check("t6_done_seen", 64'(seen), 64'd1);
        repeat (4) @(negedge clk);
        check("t6_byte_count", 64'(bytes_rx - b0), 64'd4);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
